clk_div_bank: RTL and testbench

- Synthesizable, parametrised bank of NUM_CH clock dividers driven from a single fast clock `clk`.
- Each channel produces two outputs:
  - a registered 50%-duty divided square wave;
  - a one-cycle tick on each divided rising edge.
- Half-periods are runtime-programmable and apply glitch-free. Replaces free-running delay-based divided clocks in the design.
- Downstream logic runs on `clk` and qualifies with tick; clk_out is for observation/IO only, never a clock.

---
 rtl/clk_div_bank.sv | 122 ++++++++++++
 tb/tb_clk_div_bank.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// ============================================================================
// Module   : clk_div_bank
// Purpose  : Bank of runtime-programmable 50%-duty clock dividers with ticks
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module clk_div_bank #(
  parameter int NUM_CH   = 3,
  parameter int CNT_W    = 8,
  parameter int DEF_POW2 = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sync,
  input  logic              cfg_wr,
  input  logic [3:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic r_cfg_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= cfg_wr && ({1'b0, cfg_ch} >= 5'(NUM_CH));
    end
  end

  assign cfg_err = r_cfg_err;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      localparam logic [CNT_W-1:0] c_def_half =
        (DEF_POW2 != 0) ? CNT_W'(64'd1 << i) : CNT_W'(1);

      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] r_half_act;
      logic [CNT_W-1:0] r_half_pend;
      logic             r_pend;
      logic             r_out;
      logic             r_tick;
      logic             w_hit;
      logic             w_stopped;
      logic             w_last;

      assign w_hit     = cfg_wr && (cfg_ch == 4'(i));
      assign w_stopped = (r_half_act == '0);
      assign w_last    = (r_cnt == (r_half_act - CNT_W'(1)));

      always_ff @(posedge clk) begin
        if (!rst) begin
          r_cnt       <= '0;
          r_out       <= 1'b0;
          r_tick      <= 1'b0;
          r_pend      <= 1'b0;
          r_half_pend <= '0;
          r_half_act  <= c_def_half;
        end else if (sync) begin
          // A write arriving with sync bypasses the shadow register entirely.
          r_cnt  <= '0;
          r_out  <= 1'b0;
          r_tick <= 1'b0;
          if (w_hit) begin
            r_half_act <= cfg_half;
            r_pend     <= 1'b0;
          end else if (r_pend) begin
            r_half_act <= r_half_pend;
            r_pend     <= 1'b0;
          end
        end else if (!en) begin
          r_tick <= 1'b0;
          if (w_hit) begin
            r_half_pend <= cfg_half;
            r_pend      <= 1'b1;
          end
        end else if (w_stopped) begin
          r_cnt  <= '0;
          r_out  <= 1'b0;
          r_tick <= 1'b0;
          if (r_pend) begin
            r_half_act <= r_half_pend;
          end
          r_pend <= w_hit;
          if (w_hit) begin
            r_half_pend <= cfg_half;
          end
        end else begin
          if (w_last) begin
            r_cnt  <= '0;
            r_out  <= ~r_out;
            r_tick <= ~r_out;
            // Apply only at the end of the high phase so no runt period appears.
            if (r_out && r_pend) begin
              r_half_act <= r_half_pend;
              r_pend     <= 1'b0;
            end
          end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_tick <= 1'b0;
          end
          if (w_hit) begin
            r_half_pend <= cfg_half;
            r_pend      <= 1'b1;
          end
        end
      end

      assign clk_out[i] = r_out;
      assign tick[i]    = r_tick;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_clk_div_bank.sv
// ============================================================================
// Module   : tb_clk_div_bank
// Purpose  : Directed and random stimulus against a phase-based divider model
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_clk_div_bank;

  localparam int NUM_CH   = 3;
  localparam int CNT_W    = 8;
  localparam int DEF_POW2 = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              sync;
  logic              cfg_wr;
  logic [3:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_half;
  logic              cfg_err;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  always #5 clk = ~clk;

  clk_div_bank #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .DEF_POW2(DEF_POW2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sync    (sync),
    .cfg_wr  (cfg_wr),
    .cfg_ch  (cfg_ch),
    .cfg_half(cfg_half),
    .cfg_err (cfg_err),
    .clk_out (clk_out),
    .tick    (tick)
  );

  // Model: each channel is a position within its 2*half-cycle period.
  int                m_h   [NUM_CH];
  int                m_hp  [NUM_CH];
  int                m_ph  [NUM_CH];
  bit                m_pend[NUM_CH];
  logic [NUM_CH-1:0] m_tick;
  logic              m_err;

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [NUM_CH-1:0] m_out();
    logic [NUM_CH-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      r[i] = (m_h[i] != 0) && (m_ph[i] >= m_h[i]);
    end
    return r;
  endfunction

  task automatic model_edge();
    bit hit;
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_h[i]    = (DEF_POW2 != 0) ? ((1 << i) & ((1 << CNT_W) - 1)) : 1;
        m_hp[i]   = 0;
        m_ph[i]   = 0;
        m_pend[i] = 1'b0;
      end
      m_tick = '0;
      m_err  = 1'b0;
      return;
    end
    m_err = cfg_wr && (int'(cfg_ch) >= NUM_CH);
    for (int i = 0; i < NUM_CH; i++) begin
      hit = cfg_wr && (int'(cfg_ch) == i);
      m_tick[i] = 1'b0;
      if (sync) begin
        m_ph[i] = 0;
        if (hit) begin
          m_h[i]    = int'(cfg_half);
          m_pend[i] = 1'b0;
        end else if (m_pend[i]) begin
          m_h[i]    = m_hp[i];
          m_pend[i] = 1'b0;
        end
      end else if (!en) begin
        if (hit) begin
          m_hp[i]   = int'(cfg_half);
          m_pend[i] = 1'b1;
        end
      end else if (m_h[i] == 0) begin
        m_ph[i] = 0;
        if (m_pend[i]) begin
          m_h[i]    = m_hp[i];
          m_pend[i] = 1'b0;
        end
        if (hit) begin
          m_hp[i]   = int'(cfg_half);
          m_pend[i] = 1'b1;
        end
      end else begin
        m_ph[i]   = (m_ph[i] + 1) % (2 * m_h[i]);
        m_tick[i] = (m_ph[i] == m_h[i]);
        if (m_ph[i] == 0 && m_pend[i]) begin
          m_h[i]    = m_hp[i];
          m_pend[i] = 1'b0;
        end
        if (hit) begin
          m_hp[i]   = int'(cfg_half);
          m_pend[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cmp("clk_out", 32'(clk_out), 32'(m_out()));
    cmp("tick", 32'(tick), 32'(m_tick));
    cmp("cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wr(input int ch, input int half);
    cfg_wr   = 1'b1;
    cfg_ch   = 4'(ch);
    cfg_half = CNT_W'(half);
    step();
    cfg_wr   = 1'b0;
  endtask

  initial begin
    logic [NUM_CH-1:0] mo;
    int                guard;

    rst = 1'b0; en = 1'b0; sync = 1'b0;
    cfg_wr = 1'b0; cfg_ch = '0; cfg_half = '0;
    run(3);
    cmp("reset_clk_out", 32'(clk_out), 32'd0);

    // Default periods 2/4/8
    rst = 1'b1; en = 1'b1;
    run(24);

    // Change ch1 while its output is high
    mo = m_out();
    guard = 0;
    while (!mo[1] && guard < 20) begin
      step();
      mo = m_out();
      guard++;
    end
    cmp("ch1_high_before_write", 32'(mo[1]), 32'd1);
    wr(1, 3);
    run(30);

    // Sync realignment
    run(int'($urandom_range(3, 12)));
    sync = 1'b1;
    step();
    sync = 1'b0;
    cmp("sync_all_low", 32'(clk_out), 32'd0);
    run(20);

    // Stop and restart ch2
    wr(2, 0);
    run(20);
    cmp("ch2_stopped", 32'(clk_out[2]), 32'd0);
    wr(2, 5);
    run(25);

    // Enable freeze and invalid channel write
    en = 1'b0;
    run(7);
    en = 1'b1;
    run(10);
    wr(5, 9);
    run(3);

    // Sync coincident with a write to ch0
    sync = 1'b1;
    wr(0, 2);
    sync = 1'b0;
    run(10);

    // Reset while a write to ch0 is pending
    en = 1'b0;
    wr(0, 7);
    rst = 1'b0;
    step();
    rst = 1'b1;
    en  = 1'b1;
    run(12);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      en       = ($urandom % 8) != 0;
      sync     = ($urandom % 40) == 0;
      cfg_wr   = ($urandom % 10) == 0;
      cfg_ch   = 4'($urandom_range(0, 4));
      cfg_half = (($urandom % 16) == 0) ? CNT_W'($urandom_range(0, 255))
                                        : CNT_W'($urandom_range(0, 6));
      step();
    end
    cfg_wr = 1'b0; sync = 1'b0; en = 1'b1;
    run(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
